// File: rtl/power_trigger.sv
// Energy detector: raises trigger while |I| exceeds power_thres, drops it after a low run.
// Latency: 2 enabled cycles from sample_in to sample_out, with trigger aligned to sample_out.
// Backpressure: none; enable=0 freezes all state and drops incoming strobes.
module power_trigger #(
    parameter int SKIP_WIDTH = 32,
    parameter int WIN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           sample_in,
    input  logic                  sample_in_strobe,
    input  logic [15:0]           power_thres,
    input  logic [WIN_WIDTH-1:0]  window_size,
    input  logic [SKIP_WIDTH-1:0] num_sample_to_skip,
    input  logic                  num_sample_changed,
    output logic                  trigger,
    output logic [31:0]           sample_out,
    output logic                  sample_out_strobe
);

    typedef enum logic [1:0] {
        S_SKIP,
        S_IDLE,
        S_PACKET
    } state_t;

    state_t state, state_nxt;

    logic [SKIP_WIDTH-1:0] skip_cnt, skip_nxt, skip_inc;
    logic [WIN_WIDTH-1:0]  low_cnt, low_nxt, low_inc, win_eff;
    logic                  trig_nxt;

    logic [15:0] i_raw;
    logic [15:0] abs_i;
    logic [15:0] s1_abs;
    logic [31:0] s1_dat;
    logic        s1_vld;
    logic        above;

    // -32768 has no positive counterpart in 16 bits, so it saturates.
    assign i_raw = sample_in[31:16];
    always_comb begin
        abs_i = i_raw;
        if (i_raw[15]) begin
            if (i_raw == 16'h8000) begin
                abs_i = 16'h7FFF;
            end else begin
                abs_i = ~i_raw + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_abs <= 16'd0;
            s1_dat <= 32'd0;
            s1_vld <= 1'b0;
        end else if (enable) begin
            s1_abs <= abs_i;
            s1_dat <= sample_in;
            s1_vld <= sample_in_strobe;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sample_out        <= 32'd0;
            sample_out_strobe <= 1'b0;
        end else if (!enable) begin
            sample_out_strobe <= 1'b0;
        end else begin
            sample_out        <= s1_dat;
            sample_out_strobe <= s1_vld;
        end
    end

    assign above    = (s1_abs > power_thres);
    assign skip_inc = (&skip_cnt) ? skip_cnt : skip_cnt + SKIP_WIDTH'(1);
    assign low_inc  = (&low_cnt) ? low_cnt : low_cnt + WIN_WIDTH'(1);
    assign win_eff  = (window_size == '0) ? WIN_WIDTH'(1) : window_size;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_SKIP;
            skip_cnt <= '0;
            low_cnt  <= '0;
            trigger  <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            low_cnt  <= low_nxt;
            trigger  <= trig_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        low_nxt   = low_cnt;
        trig_nxt  = trigger;
        if (num_sample_changed) begin
            state_nxt = S_SKIP;
            skip_nxt  = '0;
            low_nxt   = '0;
            trig_nxt  = 1'b0;
        end else if (enable) begin
            case (state)
                S_SKIP: begin
                    trig_nxt = 1'b0;
                    // >= also covers a skip count lowered below the progress so far.
                    if (num_sample_to_skip == '0 || skip_cnt >= num_sample_to_skip) begin
                        state_nxt = S_IDLE;
                    end else if (s1_vld) begin
                        skip_nxt = skip_inc;
                        if (skip_inc >= num_sample_to_skip) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (s1_vld && above) begin
                        trig_nxt  = 1'b1;
                        low_nxt   = '0;
                        state_nxt = S_PACKET;
                    end
                end
                S_PACKET: begin
                    if (s1_vld) begin
                        if (above) begin
                            low_nxt = '0;
                        end else if (low_inc >= win_eff) begin
                            trig_nxt  = 1'b0;
                            low_nxt   = '0;
                            state_nxt = S_IDLE;
                        end else begin
                            low_nxt = low_inc;
                        end
                    end
                end
                default: begin
                    state_nxt = S_SKIP;
                    skip_nxt  = '0;
                    low_nxt   = '0;
                    trig_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_trigger.sv
// Directed bench for power_trigger: skip phase, hysteresis, threshold edges, restart, enable, sparse strobes.
// Outputs are sampled 1 time unit after the rising edge.
module tb_power_trigger;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic [15:0] power_thres;
    logic [15:0] window_size;
    logic [31:0] num_sample_to_skip;
    logic        num_sample_changed;
    logic        trigger;
    logic [31:0] sample_out;
    logic        sample_out_strobe;

    int checks;
    int errors;

    power_trigger #(.SKIP_WIDTH(32), .WIN_WIDTH(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .sample_in          (sample_in),
        .sample_in_strobe   (sample_in_strobe),
        .power_thres        (power_thres),
        .window_size        (window_size),
        .num_sample_to_skip (num_sample_to_skip),
        .num_sample_changed (num_sample_changed),
        .trigger            (trigger),
        .sample_out         (sample_out),
        .sample_out_strobe  (sample_out_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // After drive() for sample j returns, the outputs present sample j-1.
    task automatic drive(input logic [15:0] i_val, input logic [15:0] tag, input logic stb);
        sample_in        = {i_val, tag};
        sample_in_strobe = stb;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] skip);
        reset              = 1'b1;
        enable             = 1'b1;
        sample_in          = 32'd0;
        sample_in_strobe   = 1'b0;
        num_sample_changed = 1'b0;
        num_sample_to_skip = skip;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        power_thres = 16'd100;
        window_size = 16'd4;
        do_reset(32'd10);
        checks++;
        if (trigger !== 1'b0) begin
            errors++;
            $display("FAIL reset_trigger got %b want 0", trigger);
        end
        checks++;
        if (sample_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_sample_out got %h want 0", sample_out);
        end
        checks++;
        if (sample_out_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe got %b want 0", sample_out_strobe);
        end
    endtask

    task automatic test_skip;
        logic exp;
        power_thres = 16'd100;
        window_size = 16'd4;
        do_reset(32'd10);
        for (int j = 1; j <= 14; j++) begin
            drive(16'd500, 16'(j), 1'b1);
            if (j >= 2) begin
                exp = (j - 1 >= 11);
                checks++;
                if (sample_out_strobe !== 1'b1 || sample_out[15:0] !== 16'(j - 1)) begin
                    errors++;
                    $display("FAIL skip_latency k=%0d got stb=%b tag=%0d want stb=1 tag=%0d",
                             j - 1, sample_out_strobe, sample_out[15:0], j - 1);
                end
                checks++;
                if (trigger !== exp) begin
                    errors++;
                    $display("FAIL skip_trigger k=%0d got %b want %b", j - 1, trigger, exp);
                end
            end
        end
    endtask

    task automatic test_hysteresis;
        logic [15:0] iv;
        logic        exp;
        int          k;
        power_thres = 16'd100;
        window_size = 16'd4;
        do_reset(32'd0);
        for (int j = 1; j <= 18; j++) begin
            if (j <= 8)       iv = 16'd200;
            else if (j <= 11) iv = 16'd50;
            else if (j == 12) iv = 16'd200;
            else              iv = 16'd50;
            drive(iv, 16'(j), j <= 16);
            if (j >= 2) begin
                k   = j - 1;
                exp = (k <= 15);
                checks++;
                if (trigger !== exp) begin
                    errors++;
                    $display("FAIL hyst_trigger k=%0d got %b want %b", k, trigger, exp);
                end
            end
        end
    endtask

    task automatic test_threshold;
        logic exp;
        int   k;
        window_size = 16'd4;
        power_thres = 16'd100;
        do_reset(32'd0);
        for (int j = 1; j <= 7; j++) begin
            power_thres = (j <= 4) ? 16'd100 : 16'd32766;
            drive((j <= 4) ? 16'd100 : 16'h8000, 16'(j), j <= 6);
            if (j >= 2) begin
                k   = j - 1;
                exp = (k >= 5);
                checks++;
                if (trigger !== exp) begin
                    errors++;
                    $display("FAIL thres_trigger k=%0d got %b want %b", k, trigger, exp);
                end
            end
        end
    endtask

    task automatic test_restart;
        logic exp;
        int   k;
        power_thres = 16'd100;
        window_size = 16'd4;
        do_reset(32'd0);
        for (int j = 1; j <= 13; j++) begin
            if (j == 5) begin
                num_sample_to_skip = 32'd5;
                num_sample_changed = 1'b1;
            end else begin
                num_sample_changed = 1'b0;
            end
            drive(16'd1000, 16'(j), 1'b1);
            if (j >= 2) begin
                k   = j - 1;
                exp = (k <= 3) || (k >= 10);
                checks++;
                if (trigger !== exp) begin
                    errors++;
                    $display("FAIL restart_trigger k=%0d got %b want %b", k, trigger, exp);
                end
                checks++;
                if (sample_out_strobe !== 1'b1 || sample_out[15:0] !== 16'(k)) begin
                    errors++;
                    $display("FAIL restart_flow k=%0d got stb=%b tag=%0d want stb=1 tag=%0d",
                             k, sample_out_strobe, sample_out[15:0], k);
                end
            end
        end
        num_sample_changed = 1'b0;
    endtask

    task automatic test_enable;
        logic exp;
        int   k;
        power_thres = 16'd100;
        window_size = 16'd4;
        do_reset(32'd0);
        for (int j = 1; j <= 5; j++) begin
            drive((j <= 3) ? 16'd200 : 16'd50, 16'(j), 1'b1);
            if (j >= 2) begin
                checks++;
                if (trigger !== 1'b1 || sample_out[15:0] !== 16'(j - 1)) begin
                    errors++;
                    $display("FAIL en_pre k=%0d got trig=%b tag=%0d want trig=1 tag=%0d",
                             j - 1, trigger, sample_out[15:0], j - 1);
                end
            end
        end
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(16'd50, 16'd99, 1'b1);
            checks++;
            if (sample_out_strobe !== 1'b0 || trigger !== 1'b1 || sample_out[15:0] !== 16'd4) begin
                errors++;
                $display("FAIL en_hold c=%0d got stb=%b trig=%b tag=%0d want stb=0 trig=1 tag=4",
                         c, sample_out_strobe, trigger, sample_out[15:0]);
            end
        end
        enable = 1'b1;
        for (int j = 6; j <= 9; j++) begin
            drive((j <= 7) ? 16'd50 : 16'd0, 16'(j), j <= 7);
            k   = j - 1;
            exp = (k <= 6);
            checks++;
            if (trigger !== exp) begin
                errors++;
                $display("FAIL en_resume_trigger k=%0d got %b want %b", k, trigger, exp);
            end
            checks++;
            if (sample_out_strobe !== (k <= 7)) begin
                errors++;
                $display("FAIL en_resume_strobe k=%0d got %b want %b", k, sample_out_strobe, (k <= 7));
            end
        end
    endtask

    task automatic test_sparse;
        logic exp_trig;
        logic exp_stb;
        logic stb;
        int   k;
        int   kk;
        power_thres = 16'd100;
        window_size = 16'd3;
        do_reset(32'd0);
        exp_trig = 1'b0;
        k        = 0;
        for (int c = 0; c < 20; c++) begin
            stb = (c % 4 == 0) && (c < 16);
            if (stb) k++;
            drive((stb && k == 1) ? 16'd200 : 16'd50, stb ? 16'(k) : 16'hFFFF, stb);
            exp_stb = (c >= 1) && ((c - 1) % 4 == 0) && (c - 1 < 16);
            checks++;
            if (sample_out_strobe !== exp_stb) begin
                errors++;
                $display("FAIL sparse_strobe c=%0d got %b want %b", c, sample_out_strobe, exp_stb);
            end
            if (exp_stb) begin
                kk       = (c - 1) / 4 + 1;
                exp_trig = (kk <= 3);
                checks++;
                if (sample_out[15:0] !== 16'(kk)) begin
                    errors++;
                    $display("FAIL sparse_tag c=%0d got %0d want %0d", c, sample_out[15:0], kk);
                end
            end
            checks++;
            if (trigger !== exp_trig) begin
                errors++;
                $display("FAIL sparse_trigger c=%0d got %b want %b", c, trigger, exp_trig);
            end
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        reset              = 1'b1;
        enable             = 1'b1;
        sample_in          = 32'd0;
        sample_in_strobe   = 1'b0;
        power_thres        = 16'd100;
        window_size        = 16'd4;
        num_sample_to_skip = 32'd0;
        num_sample_changed = 1'b0;
        test_reset();
        test_skip();
        test_hysteresis();
        test_threshold();
        test_restart();
        test_enable();
        test_sparse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
